// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA digit renderer:
//   - 640x480@60 raster timing (800 x 525 total, 25 MHz pixel clock)
//   - text-box geometry (8 cells of 8x16 glyphs scaled x4)
//   - the 10-entry 8x16 digit glyph bitmap table
//   - a packed bundle for the sync/enable flags that travel down the pipeline
// ---------------------------------------------------------------------------
package vga_pkg;

    // Horizontal timing, in pixel clocks
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    // Vertical timing, in lines
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Counter-width versions of the timing points
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACTIVE     = 10'(H_VISIBLE);
    localparam logic [9:0] V_ACTIVE     = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // The shadow buffer is published on the first pixel of vertical blanking
    localparam logic [9:0] COPY_LINE = 10'(V_VISIBLE);

    // Text-box geometry
    localparam int NUM_CELLS   = 8;
    localparam int GLYPH_W     = 8;
    localparam int GLYPH_ROWS  = 16;
    localparam int GLYPH_COUNT = 10;
    localparam int GLYPH_SCALE = 4;
    localparam int CELL_W      = GLYPH_W * GLYPH_SCALE;
    localparam int CELL_H      = GLYPH_ROWS * GLYPH_SCALE;
    localparam int BOX_W       = NUM_CELLS * CELL_W;
    localparam int BOX_H       = CELL_H;
    localparam int CELL_SHIFT  = $clog2(CELL_W);
    localparam int SCALE_SHIFT = $clog2(GLYPH_SCALE);

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Digit glyphs, 16 rows of 8 bits per digit, bit 7 is the leftmost pixel.
    // Seven-segment style strokes two rows / two columns thick.
    localparam logic [7:0] GLYPH_TABLE [0:GLYPH_COUNT*GLYPH_ROWS-1] = '{
        // 0
        8'h00, 8'hFF, 8'hFF, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'h00,
        8'h00, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hFF, 8'hFF, 8'h00,
        // 1
        8'h00, 8'h00, 8'h00, 8'h03, 8'h03, 8'h03, 8'h03, 8'h00,
        8'h00, 8'h03, 8'h03, 8'h03, 8'h03, 8'h00, 8'h00, 8'h00,
        // 2
        8'h00, 8'hFF, 8'hFF, 8'h03, 8'h03, 8'h03, 8'h03, 8'hFF,
        8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'h00,
        // 3
        8'h00, 8'hFF, 8'hFF, 8'h03, 8'h03, 8'h03, 8'h03, 8'hFF,
        8'hFF, 8'h03, 8'h03, 8'h03, 8'h03, 8'hFF, 8'hFF, 8'h00,
        // 4
        8'h00, 8'h00, 8'h00, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hFF,
        8'hFF, 8'h03, 8'h03, 8'h03, 8'h03, 8'h00, 8'h00, 8'h00,
        // 5
        8'h00, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF,
        8'hFF, 8'h03, 8'h03, 8'h03, 8'h03, 8'hFF, 8'hFF, 8'h00,
        // 6
        8'h00, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF,
        8'hFF, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hFF, 8'hFF, 8'h00,
        // 7
        8'h00, 8'hFF, 8'hFF, 8'h03, 8'h03, 8'h03, 8'h03, 8'h00,
        8'h00, 8'h03, 8'h03, 8'h03, 8'h03, 8'h00, 8'h00, 8'h00,
        // 8
        8'h00, 8'hFF, 8'hFF, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hFF,
        8'hFF, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hFF, 8'hFF, 8'h00,
        // 9
        8'h00, 8'hFF, 8'hFF, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hFF,
        8'hFF, 8'h03, 8'h03, 8'h03, 8'h03, 8'hFF, 8'hFF, 8'h00
    };

    // Sync/enable flags for one pixel; delayed alongside the colour path
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } sync_t;

    // Idle values: syncs inactive (high), nothing visible, no frame pulse
    localparam sync_t SYNC_RESET = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0};

    // Raster flags for a given counter position
    function automatic sync_t timing_flags(input logic [9:0] h, input logic [9:0] v);
        sync_t s;
        s.hs = !((h >= H_SYNC_FIRST) && (h <= H_SYNC_LAST));
        s.vs = !((v >= V_SYNC_FIRST) && (v <= V_SYNC_LAST));
        s.de = (h < H_ACTIVE) && (v < V_ACTIVE);
        s.fs = (h == 10'd0) && (v == 10'd0);
        return s;
    endfunction

endpackage

// File: rtl/digit_glyph_rom.sv
// ---------------------------------------------------------------------------
// digit_glyph_rom
// Combinational lookup of one glyph pixel.
//   i_code : digit code, 0-9 draw a glyph, 10-15 are blank
//   i_row  : glyph row 0-15 (top to bottom)
//   i_col  : glyph column 0-7, column 0 is the MSB of the row
//   o_bit  : 1 when the pixel belongs to the glyph stroke
// ---------------------------------------------------------------------------
module digit_glyph_rom
    import vga_pkg::*;
(
    input  logic [3:0] i_code,
    input  logic [3:0] i_row,
    input  logic [2:0] i_col,
    output logic       o_bit
);

    logic [7:0] w_rowBits;

    // Codes past the last digit fall back to an empty row
    always_comb begin
        w_rowBits = 8'h00;
        if (i_code < 4'(GLYPH_COUNT)) begin
            w_rowBits = GLYPH_TABLE[{i_code, i_row}];
        end
    end

    assign o_bit = w_rowBits[3'd7 - i_col];

endmodule

// File: rtl/vga_digit_renderer.sv
// ---------------------------------------------------------------------------
// vga_digit_renderer
// 640x480@60 raster generator that draws an 8-digit text box.
//   clk, rst_n          : 25 MHz pixel clock, async active-low reset
//   wr_valid/wr_ready   : host write handshake into the shadow buffer
//   wr_addr, wr_data    : digit slot (0 = leftmost) and digit code
//   vga_hs, vga_vs      : active-low syncs
//   vga_de              : visible-area enable
//   vga_r/g/b           : 4-bit colour channels
//   frame_start         : one-cycle pulse for pixel (0,0) on the pins
// Counter position to pins is three registers deep; the sync flags ride
// along with the colour so everything leaves aligned.
// ---------------------------------------------------------------------------
module vga_digit_renderer
    import vga_pkg::*;
#(
    parameter logic [11:0] FG_RGB = 12'hFFF,
    parameter logic [11:0] BG_RGB = 12'h000,
    parameter int          X0     = 192,
    parameter int          Y0     = 208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_de,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       frame_start
);

    // Box edges in counter width; the right/bottom edges are exclusive
    localparam logic [9:0] BOX_X0 = 10'(X0);
    localparam logic [9:0] BOX_X1 = 10'(X0 + BOX_W);
    localparam logic [9:0] BOX_Y0 = 10'(Y0);
    localparam logic [9:0] BOX_Y1 = 10'(Y0 + BOX_H);

    logic [9:0]  r_hCount;
    logic [9:0]  r_vCount;
    logic        r_readyEn;
    logic        w_copyCycle;
    logic        w_writeFire;
    logic [3:0]  r_shadow  [NUM_CELLS];
    logic [3:0]  r_display [NUM_CELLS];

    logic [9:0]  r_s1H;
    logic [9:0]  r_s1V;
    sync_t       r_s1Sync;

    logic        w_inBox;
    logic [2:0]  w_cell;
    logic [2:0]  w_col;
    logic [3:0]  w_row;
    logic [3:0]  r_s2Code;
    logic [3:0]  r_s2Row;
    logic [2:0]  r_s2Col;
    logic        r_s2InBox;
    sync_t       r_s2Sync;

    logic        w_glyphBit;
    sync_t       r_outSync;
    logic [11:0] r_rgb;

    // Raster counters: h wraps at the end of a line and carries into v
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hCount <= '0;
            r_vCount <= '0;
        end else if (r_hCount == H_LAST) begin
            r_hCount <= '0;
            r_vCount <= (r_vCount == V_LAST) ? 10'd0 : r_vCount + 10'd1;
        end else begin
            r_hCount <= r_hCount + 10'd1;
        end
    end

    // The copy cycle is the single counter position (0, first blank line)
    assign w_copyCycle = (r_hCount == 10'd0) && (r_vCount == COPY_LINE);

    // Ready comes up on the first edge out of reset and drops only while
    // the shadow is being published, so a held write simply slips a cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_readyEn <= 1'b0;
        end else begin
            r_readyEn <= 1'b1;
        end
    end

    assign wr_ready    = r_readyEn && !w_copyCycle;
    assign w_writeFire = wr_valid && wr_ready;

    // Host writes collect in the shadow; repeated writes to a slot overwrite
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                r_shadow[i] <= BLANK_CODE;
            end
        end else if (w_writeFire) begin
            r_shadow[wr_addr] <= wr_data;
        end
    end

    // The display copy only changes at the start of vertical blanking, so a
    // frame never shows a mix of old and new digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                r_display[i] <= BLANK_CODE;
            end
        end else if (w_copyCycle) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                r_display[i] <= r_shadow[i];
            end
        end
    end

    // Stage 1: snapshot the counters and derive their raster flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1H    <= '0;
            r_s1V    <= '0;
            r_s1Sync <= SYNC_RESET;
        end else begin
            r_s1H    <= r_hCount;
            r_s1V    <= r_vCount;
            r_s1Sync <= timing_flags(r_hCount, r_vCount);
        end
    end

    // Box-relative decode; offsets are only meaningful when w_inBox is set
    assign w_inBox = (r_s1H >= BOX_X0) && (r_s1H < BOX_X1) &&
                     (r_s1V >= BOX_Y0) && (r_s1V < BOX_Y1);
    assign w_cell  = 3'((r_s1H - BOX_X0) >> CELL_SHIFT);
    assign w_col   = 3'((r_s1H - BOX_X0) >> SCALE_SHIFT);
    assign w_row   = 4'((r_s1V - BOX_Y0) >> SCALE_SHIFT);

    // Stage 2: cell lookup in the display buffer plus glyph row/column
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2Code  <= BLANK_CODE;
            r_s2Row   <= '0;
            r_s2Col   <= '0;
            r_s2InBox <= 1'b0;
            r_s2Sync  <= SYNC_RESET;
        end else begin
            r_s2Code  <= r_display[w_cell];
            r_s2Row   <= w_row;
            r_s2Col   <= w_col;
            r_s2InBox <= w_inBox;
            r_s2Sync  <= r_s1Sync;
        end
    end

    digit_glyph_rom u_glyphRom (
        .i_code (r_s2Code),
        .i_row  (r_s2Row),
        .i_col  (r_s2Col),
        .o_bit  (w_glyphBit)
    );

    // Stage 3: colour select; anything outside the visible area is black
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outSync <= SYNC_RESET;
            r_rgb     <= '0;
        end else begin
            r_outSync <= r_s2Sync;
            if (!r_s2Sync.de) begin
                r_rgb <= '0;
            end else if (r_s2InBox && w_glyphBit) begin
                r_rgb <= FG_RGB;
            end else begin
                r_rgb <= BG_RGB;
            end
        end
    end

    assign vga_hs      = r_outSync.hs;
    assign vga_vs      = r_outSync.vs;
    assign vga_de      = r_outSync.de;
    assign frame_start = r_outSync.fs;
    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];

endmodule

// File: tb/tb_vga_digit_renderer.sv
// ---------------------------------------------------------------------------
// tb_vga_digit_renderer
// Directed bench for the digit renderer. `cycle` counts rising edges since
// reset release; after edge k the pins show counter position k-3, i.e.
// pixel (h,v) of frame f appears after edge f*420000 + v*800 + h + 3.
// ---------------------------------------------------------------------------
module tb_vga_digit_renderer;

    localparam logic [11:0] FG = 12'hEA5;
    localparam logic [11:0] BG = 12'h124;
    localparam int          FRAME = 420000;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_de;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       frame_start;

    int          checks;
    int          failures;
    int unsigned cycle;
    logic [11:0] rgb;

    assign rgb = {vga_r, vga_g, vga_b};

    vga_digit_renderer #(
        .FG_RGB (FG),
        .BG_RGB (BG),
        .X0     (192),
        .Y0     (208)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_de      (vga_de),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start)
    );

    // 25 MHz pixel clock
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Edge counter since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycle <= 0;
        else        cycle <= cycle + 1;
    end

    // Advance to 1 time unit after edge `target`; overshooting is a failure
    task automatic wait_cycle(input int unsigned target);
        if (cycle > target) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_cycle: now at %0d, required %0d", cycle, target);
        end
        while (cycle < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One host write, presented for a single cycle
    task automatic applyStimulus(input logic [2:0] addr, input logic [3:0] data);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (vga_hs !== 1'b1)    begin failures++; $display("[TB] FAIL reset_hs: got %b need 1", vga_hs); end
        checks++; if (vga_vs !== 1'b1)    begin failures++; $display("[TB] FAIL reset_vs: got %b need 1", vga_vs); end
        checks++; if (vga_de !== 1'b0)    begin failures++; $display("[TB] FAIL reset_de: got %b need 0", vga_de); end
        checks++; if (rgb !== 12'h000)    begin failures++; $display("[TB] FAIL reset_rgb: got %h need 000", rgb); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_fs: got %b need 0", frame_start); end
        checks++; if (wr_ready !== 1'b0)  begin failures++; $display("[TB] FAIL reset_ready: got %b need 0", wr_ready); end
    endtask

    // Release and first-frame alignment; used after both resets
    task automatic test_startup(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("[TB] FAIL %s_ready_pre: got %b need 0", tag, wr_ready); end
        wait_cycle(1);
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL %s_ready_rise: got %b need 1", tag, wr_ready); end
        wait_cycle(2);
        checks++; if (frame_start !== 1'b0 || vga_de !== 1'b0) begin failures++; $display("[TB] FAIL %s_pre_fs: got fs=%b de=%b need 0 0", tag, frame_start, vga_de); end
        wait_cycle(3);
        checks++; if (frame_start !== 1'b1 || vga_de !== 1'b1 || rgb !== BG) begin failures++; $display("[TB] FAIL %s_first_pixel: got fs=%b de=%b rgb=%h need 1 1 %h", tag, frame_start, vga_de, rgb, BG); end
        wait_cycle(4);
        checks++; if (frame_start !== 1'b0) begin failures++; $display("[TB] FAIL %s_fs_width: got %b need 0", tag, frame_start); end
    endtask

    task automatic test_hsync();
        int   firstFall  = -1;
        int   secondFall = -1;
        int   lowCount   = 0;
        logic prevHs     = 1'b1;
        for (int k = 600; k <= 1500; k++) begin
            wait_cycle(k);
            if (prevHs && !vga_hs) begin
                if (firstFall < 0) firstFall = k;
                else if (secondFall < 0) secondFall = k;
            end
            if (!vga_hs && secondFall < 0) lowCount++;
            prevHs = vga_hs;
        end
        checks++; if (firstFall != 659) begin failures++; $display("[TB] FAIL hs_fall: got %0d need 659", firstFall); end
        checks++; if (lowCount != 96)   begin failures++; $display("[TB] FAIL hs_width: got %0d need 96", lowCount); end
        checks++; if (secondFall - firstFall != 800) begin failures++; $display("[TB] FAIL hs_period: got %0d need 800", secondFall - firstFall); end
    endtask

    task automatic test_shadow_writes();
        wait_cycle(2000);
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL write_ready: got %b need 1", wr_ready); end
        applyStimulus(3'd0, 4'd8);
        applyStimulus(3'd3, 4'd1);
        applyStimulus(3'd7, 4'd1);
        applyStimulus(3'd7, 4'd12);
    endtask

    task automatic test_blank_before_copy();
        // (X0, Y0+4) of frame 0: written digit must not show yet
        wait_cycle(212*800 + 192 + 3);
        checks++; if (rgb !== BG || vga_de !== 1'b1) begin failures++; $display("[TB] FAIL pre_copy_pixel: got rgb=%h de=%b need %h 1", rgb, vga_de, BG); end
    endtask

    task automatic test_copy_handshake();
        wait_cycle(383999);
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL copy_ready_before: got %b need 1", wr_ready); end
        wait_cycle(384000);
        wr_valid = 1'b1;
        wr_addr  = 3'd2;
        wr_data  = 4'd8;
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("[TB] FAIL copy_ready_low: got %b need 0", wr_ready); end
        wait_cycle(384001);
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL copy_ready_after: got %b need 1", wr_ready); end
        wait_cycle(384002);
        wr_valid = 1'b0;
    endtask

    task automatic test_vsync();
        int   firstFall = -1;
        int   lowCount  = 0;
        logic prevVs    = 1'b1;
        for (int k = 391990; k <= 393700; k++) begin
            wait_cycle(k);
            if (prevVs && !vga_vs && firstFall < 0) firstFall = k;
            if (!vga_vs) lowCount++;
            prevVs = vga_vs;
        end
        checks++; if (firstFall != 392003) begin failures++; $display("[TB] FAIL vs_fall: got %0d need 392003", firstFall); end
        checks++; if (lowCount != 1600)    begin failures++; $display("[TB] FAIL vs_width: got %0d need 1600", lowCount); end
    endtask

    task automatic test_blanking_rgb();
        // line 500, h=100: vertical blanking, vs inactive
        wait_cycle(500*800 + 100 + 3);
        checks++; if (vga_de !== 1'b0 || rgb !== 12'h000 || vga_vs !== 1'b1) begin failures++; $display("[TB] FAIL vblank_rgb: got de=%b rgb=%h vs=%b need 0 000 1", vga_de, rgb, vga_vs); end
    endtask

    task automatic test_frame_period();
        wait_cycle(FRAME + 2);
        checks++; if (frame_start !== 1'b0) begin failures++; $display("[TB] FAIL fs_period_early: got %b need 0", frame_start); end
        wait_cycle(FRAME + 3);
        checks++; if (frame_start !== 1'b1) begin failures++; $display("[TB] FAIL fs_period: got %b need 1", frame_start); end
        wait_cycle(FRAME + 4);
        checks++; if (frame_start !== 1'b0) begin failures++; $display("[TB] FAIL fs_period_late: got %b need 0", frame_start); end
    endtask

    task automatic test_glyph_pixels();
        // line Y0 (208): glyph row 0 of '8' is empty
        wait_cycle(FRAME + 208*800 + 191 + 3);
        checks++; if (rgb !== BG) begin failures++; $display("[TB] FAIL row0_left: got %h need %h", rgb, BG); end
        wait_cycle(FRAME + 208*800 + 192 + 3);
        checks++; if (rgb !== BG) begin failures++; $display("[TB] FAIL row0_x0: got %h need %h", rgb, BG); end
        // line Y0+4 (212): glyph row 1
        wait_cycle(FRAME + 212*800 + 100 + 3);
        checks++; if (rgb !== BG || vga_de !== 1'b1) begin failures++; $display("[TB] FAIL outside_box: got rgb=%h de=%b need %h 1", rgb, vga_de, BG); end
        wait_cycle(FRAME + 212*800 + 191 + 3);
        checks++; if (rgb !== BG) begin failures++; $display("[TB] FAIL box_left_edge: got %h need %h", rgb, BG); end
        wait_cycle(FRAME + 212*800 + 192 + 3);
        checks++; if (rgb !== FG) begin failures++; $display("[TB] FAIL slot0_row1_col0: got %h need %h", rgb, FG); end
        wait_cycle(FRAME + 212*800 + 223 + 3);
        checks++; if (rgb !== FG) begin failures++; $display("[TB] FAIL slot0_row1_col7: got %h need %h", rgb, FG); end
        wait_cycle(FRAME + 212*800 + 224 + 3);
        checks++; if (rgb !== BG) begin failures++; $display("[TB] FAIL slot1_blank: got %h need %h", rgb, BG); end
        wait_cycle(FRAME + 212*800 + 256 + 3);
        checks++; if (rgb !== BG) begin failures++; $display("[TB] FAIL slot2_late_write: got %h need %h", rgb, BG); end
        wait_cycle(FRAME + 212*800 + 700 + 3);
        checks++; if (vga_de !== 1'b0 || rgb !== 12'h000 || vga_hs !== 1'b0) begin failures++; $display("[TB] FAIL hblank_rgb: got de=%b rgb=%h hs=%b need 0 000 0", vga_de, rgb, vga_hs); end
        // line Y0+12 (220): glyph row 3
        wait_cycle(FRAME + 220*800 + 200 + 3);
        checks++; if (rgb !== BG) begin failures++; $display("[TB] FAIL slot0_row3_col2: got %h need %h", rgb, BG); end
        wait_cycle(FRAME + 220*800 + 288 + 3);
        checks++; if (rgb !== BG) begin failures++; $display("[TB] FAIL slot3_row3_col0: got %h need %h", rgb, BG); end
        wait_cycle(FRAME + 220*800 + 316 + 3);
        checks++; if (rgb !== FG) begin failures++; $display("[TB] FAIL slot3_row3_col7: got %h need %h", rgb, FG); end
        wait_cycle(FRAME + 220*800 + 444 + 3);
        checks++; if (rgb !== BG) begin failures++; $display("[TB] FAIL slot7_last_write: got %h need %h", rgb, BG); end
    endtask

    task automatic test_mid_frame_reset();
        // counter at (100, 300) of frame 1: pins show a visible BG pixel
        wait_cycle(FRAME + 300*800 + 100);
        checks++; if (vga_de !== 1'b1 || rgb !== BG) begin failures++; $display("[TB] FAIL pre_reset_pixel: got de=%b rgb=%h need 1 %h", vga_de, rgb, BG); end
        rst_n = 1'b0;
        #1;
        test_reset();
        repeat (5) @(posedge clk);
        test_startup("rerun");
        wait_cycle(658);
        checks++; if (vga_hs !== 1'b1) begin failures++; $display("[TB] FAIL rerun_hs_pre: got %b need 1", vga_hs); end
        wait_cycle(659);
        checks++; if (vga_hs !== 1'b0) begin failures++; $display("[TB] FAIL rerun_hs_fall: got %b need 0", vga_hs); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 4'd0;
        repeat (4) @(posedge clk);
        #1;
        test_reset();
        test_startup("boot");
        test_hsync();
        test_shadow_writes();
        test_blank_before_copy();
        test_copy_handshake();
        test_vsync();
        test_blanking_rgb();
        test_frame_period();
        test_glyph_pixels();
        test_mid_frame_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
